// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the unified memory port: core priority with a bounded
// DMA starvation limit, registered request/ready transactions and a watchdog abort.
module mem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned STARVE  = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          owner,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_rdy
);

    localparam int unsigned SW = $clog2(STARVE + 1);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] StreakMax = SW'(STARVE);
    localparam logic [CW-1:0] WaitLast  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic            core_ack_q, core_ack_d;
    logic            dma_ack_q, dma_ack_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            owner_q, owner_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            dma_win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            core_ack_q  <= 1'b0;
            dma_ack_q   <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            owner_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            streak_q    <= '0;
            wcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            core_ack_q  <= core_ack_d;
            dma_ack_q   <= dma_ack_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            streak_q    <= streak_d;
            wcnt_q      <= wcnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        core_ack_d  = 1'b0;
        dma_ack_d   = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        owner_d     = owner_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        streak_d    = streak_q;
        wcnt_d      = wcnt_q;
        dma_win     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (core_req || dma_req) begin
                    // Core keeps priority until the DMA has watched STARVE core grants.
                    dma_win = dma_req && (!core_req || streak_q == StreakMax);
                    if (dma_win) begin
                        mem_we_d    = dma_we;
                        mem_addr_d  = dma_addr;
                        mem_wdata_d = dma_wdata;
                        streak_d    = '0;
                    end else begin
                        mem_we_d    = core_we;
                        mem_addr_d  = core_addr;
                        mem_wdata_d = core_wdata;
                        if (!dma_req) begin
                            streak_d = '0;
                        end else if (streak_q != StreakMax) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end
                    owner_d  = dma_win;
                    mem_en_d = 1'b1;
                    wcnt_d   = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                wcnt_d = wcnt_q + 1'b1;
                // A ready arriving on the last allowed cycle still completes normally.
                if (mem_rdy || wcnt_q == WaitLast) begin
                    mem_en_d   = 1'b0;
                    core_ack_d = !owner_q;
                    dma_ack_d  = owner_q;
                    state_d    = StDone;
                    if (mem_rdy) begin
                        if (!mem_we_q) begin
                            rdata_d = mem_rdata;
                        end
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign core_ack  = core_ack_q;
    assign dma_ack   = dma_ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign owner     = owner_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int STARVE  = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, core_ack;
    logic [31:0] core_addr, core_wdata;
    logic        dma_req, dma_we, dma_ack;
    logic [31:0] dma_addr, dma_wdata;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        err, owner, mem_en, mem_we, mem_rdy;

    int          lat;
    int          busy_cnt;
    logic        use_force;
    logic [31:0] rd_force;
    int          n_checks = 0;
    int          n_fail = 0;

    mem_arbiter #(
        .AW      (32),
        .DW      (32),
        .STARVE  (STARVE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_ack    (dma_ack),
        .rdata      (rdata),
        .err        (err),
        .owner      (owner),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rdy    (mem_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_1234;
    endfunction

    // Memory model: ready after 'lat' wait cycles of a held strobe.
    always @(posedge clk or negedge reset) begin
        if (!reset) busy_cnt <= 0;
        else        busy_cnt <= mem_en ? busy_cnt + 1 : 0;
    end
    assign mem_rdy   = mem_en && (busy_cnt == lat);
    assign mem_rdata = use_force ? rd_force : rd_fn(mem_addr);

    task automatic run_access(input bit is_dma, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, output int ack_at, output int en_cycles,
                              output int we_cycles, output logic [31:0] rd, output logic e,
                              output logic own, output int other_acks, output int addr_bad);
        bit done = 0;
        ack_at = -1; en_cycles = 0; we_cycles = 0; rd = 'x; e = 1'bx; own = 1'bx;
        other_acks = 0; addr_bad = 0;
        @(negedge clk);
        if (is_dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
        end
        for (int k = 1; k <= TIMEOUT + 6 && !done; k++) begin
            @(negedge clk);
            if (ack_at >= 0) begin
                done = 1;
            end else begin
                if (mem_en === 1'b1) begin
                    en_cycles++;
                    if (mem_we === 1'b1) we_cycles++;
                    if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wdata))
                        addr_bad++;
                end
                if ((is_dma ? core_ack : dma_ack) === 1'b1) other_acks++;
                if ((is_dma ? dma_ack : core_ack) === 1'b1) begin
                    ack_at = k; rd = rdata; e = err; own = owner;
                end
            end
        end
        core_req = 1'b0;
        dma_req  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        lat = 0; use_force = 1'b0; rd_force = '0;
        #3;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        n_checks++; if (core_ack !== 1'b0) begin n_fail++; $display("FAIL reset_core_ack: got %b expected 0", core_ack); end
        n_checks++; if (dma_ack !== 1'b0) begin n_fail++; $display("FAIL reset_dma_ack: got %b expected 0", dma_ack); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %b expected 0", owner); end
    endtask

    task automatic test_core_read();
        int ack_at, en_c, we_c, oth, bad;
        logic [31:0] rd;
        logic e, own;
        lat = 0; use_force = 1'b1; rd_force = 32'hDEADBEEF;
        run_access(1'b0, 1'b0, 32'h100, 32'h0, ack_at, en_c, we_c, rd, e, own, oth, bad);
        use_force = 1'b0;
        n_checks++; if (ack_at != 2) begin n_fail++; $display("FAIL core_read_ack_cycle: got %0d expected 2", ack_at); end
        n_checks++; if (en_c != 1) begin n_fail++; $display("FAIL core_read_en_cycles: got %0d expected 1", en_c); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL core_read_mem_addr: got %0d bad cycles expected 0", bad); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL core_read_rdata: got %h expected deadbeef", rd); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL core_read_err: got %b expected 0", e); end
        n_checks++; if (oth != 0) begin n_fail++; $display("FAIL core_read_dma_ack: got %0d pulses expected 0", oth); end
    endtask

    task automatic test_dma_write();
        int ack_at, en_c, we_c, oth, bad;
        logic [31:0] rd;
        logic e, own;
        lat = 3;
        run_access(1'b1, 1'b1, 32'h40, 32'h12345678, ack_at, en_c, we_c, rd, e, own, oth, bad);
        n_checks++; if (ack_at != 5) begin n_fail++; $display("FAIL dma_write_ack_cycle: got %0d expected 5", ack_at); end
        n_checks++; if (we_c != 4) begin n_fail++; $display("FAIL dma_write_we_cycles: got %0d expected 4", we_c); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL dma_write_mem_fields: got %0d bad cycles expected 0", bad); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dma_write_rdata_kept: got %h expected deadbeef", rd); end
        n_checks++; if (own !== 1'b1) begin n_fail++; $display("FAIL dma_write_owner: got %b expected 1", own); end
        n_checks++; if (oth != 0) begin n_fail++; $display("FAIL dma_write_core_ack: got %0d pulses expected 0", oth); end
    endtask

    task automatic test_timeout();
        int ack_at, en_c, we_c, oth, bad;
        logic [31:0] rd;
        logic e, own;
        lat = 1000;
        run_access(1'b0, 1'b0, 32'h200, 32'h0, ack_at, en_c, we_c, rd, e, own, oth, bad);
        n_checks++; if (en_c != TIMEOUT) begin n_fail++; $display("FAIL timeout_en_cycles: got %0d expected %0d", en_c, TIMEOUT); end
        n_checks++; if (ack_at != TIMEOUT + 1) begin n_fail++; $display("FAIL timeout_ack_cycle: got %0d expected %0d", ack_at, TIMEOUT + 1); end
        n_checks++; if (e !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", e); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %h expected 0", rd); end
        n_checks++; if (mem_en !== 1'b0 || core_ack !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_back_idle: got en=%b ack=%b err=%b expected 0/0/0", mem_en, core_ack, err);
        end
    endtask

    task automatic test_boundary();
        int ack_at, en_c, we_c, oth, bad;
        logic [31:0] rd;
        logic e, own;
        lat = TIMEOUT - 1;
        run_access(1'b0, 1'b0, 32'h300, 32'h0, ack_at, en_c, we_c, rd, e, own, oth, bad);
        n_checks++; if (ack_at != TIMEOUT + 1) begin n_fail++; $display("FAIL boundary_ack_cycle: got %0d expected %0d", ack_at, TIMEOUT + 1); end
        n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL boundary_err: got %b expected 0", e); end
        n_checks++; if (rd !== rd_fn(32'h300)) begin n_fail++; $display("FAIL boundary_rdata: got %h expected %h", rd, rd_fn(32'h300)); end
    endtask

    task automatic test_starvation();
        int grants = 0;
        int last_ack = 0;
        int cyc = 0;
        logic exp_dma;
        lat = 0;
        @(negedge clk);
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h1000;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h2000;
        while (grants < 10 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            n_checks++; if (core_ack === 1'b1 && dma_ack === 1'b1) begin n_fail++; $display("FAIL starve_ack_overlap: got both acks expected one"); end
            if (core_ack === 1'b1 || dma_ack === 1'b1) begin
                // The DMA owns every (STARVE+1)-th slot under continuous contention.
                exp_dma = ((grants % (STARVE + 1)) == STARVE);
                n_checks++;
                if (dma_ack !== exp_dma || owner !== exp_dma) begin
                    n_fail++;
                    $display("FAIL starve_grant_%0d: got dma_ack=%b owner=%b expected %b", grants, dma_ack, owner, exp_dma);
                end
                if (grants > 0) begin
                    n_checks++; if (cyc - last_ack != 3) begin n_fail++; $display("FAIL starve_period: got %0d expected 3", cyc - last_ack); end
                end
                last_ack = cyc;
                grants++;
            end
        end
        n_checks++; if (grants != 10) begin n_fail++; $display("FAIL starve_grant_count: got %0d expected 10", grants); end
        @(negedge clk);
        core_req = 1'b0; dma_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int ack_at, en_c, we_c, oth, bad;
        logic [31:0] rd;
        logic e, own;
        int stray = 0;
        lat = 1000;
        @(negedge clk);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_checks++; if (mem_en !== 1'b1 || owner !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got en=%b owner=%b expected 1/1", mem_en, owner); end
        reset = 1'b0;
        #1;
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_en: got %b expected 0", mem_en); end
        n_checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_mem_fields: got we=%b addr=%h wdata=%h expected 0", mem_we, mem_addr, mem_wdata);
        end
        n_checks++; if (owner !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_outputs: got owner=%b rdata=%h err=%b expected 0", owner, rdata, err);
        end
        dma_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (dma_ack !== 1'b0 || core_ack !== 1'b0) stray++;
        end
        reset = 1'b1;
        @(negedge clk);
        if (dma_ack !== 1'b0) stray++;
        n_checks++; if (stray != 0) begin n_fail++; $display("FAIL rstmid_no_ack: got %0d ack cycles expected 0", stray); end
        lat = 2;
        run_access(1'b0, 1'b0, 32'h44, 32'h0, ack_at, en_c, we_c, rd, e, own, oth, bad);
        n_checks++; if (ack_at != 4) begin n_fail++; $display("FAIL rstmid_after_ack: got %0d expected 4", ack_at); end
        n_checks++; if (rd !== rd_fn(32'h44) || e !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_after_data: got %h err=%b expected %h err=0", rd, e, rd_fn(32'h44));
        end
    endtask

    task automatic test_random();
        bit cp = 0, dp = 0, new_c, new_d, win_dma, exp_err;
        logic cwe = 1'b0, dwe = 1'b0, w_we, got_err, got_own;
        logic [31:0] ca = '0, cd = '0, da = '0, dd = '0;
        logic [31:0] w_addr, w_data, exp_rd, got_rd;
        logic [31:0] m_rdata = '0;
        int streak = 0;
        int exp_ack, ack_at, bad;
        reset = 1'b0; core_req = 1'b0; dma_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 60; t++) begin
            new_c = !cp && ($urandom_range(0, 1) == 1);
            new_d = !dp && ($urandom_range(0, 1) == 1);
            if (!cp && !dp && !new_c && !new_d) begin
                if ($urandom_range(0, 1) == 1) new_d = 1; else new_c = 1;
            end
            if (new_c) begin cp = 1; cwe = 1'($urandom_range(0, 1)); ca = $urandom; cd = $urandom; end
            if (new_d) begin dp = 1; dwe = 1'($urandom_range(0, 1)); da = $urandom; dd = $urandom; end
            core_req = cp; core_we = cwe; core_addr = ca; core_wdata = cd;
            dma_req = dp; dma_we = dwe; dma_addr = da; dma_wdata = dd;
            case ($urandom_range(0, 7))
                0:       lat = 1000;
                1:       lat = TIMEOUT - 1;
                default: lat = int'($urandom_range(0, 4));
            endcase

            win_dma = dp && (!cp || streak == STARVE);
            if (win_dma)  streak = 0;
            else if (dp)  streak = (streak < STARVE) ? streak + 1 : streak;
            else          streak = 0;
            w_we   = win_dma ? dwe : cwe;
            w_addr = win_dma ? da : ca;
            w_data = win_dma ? dd : cd;
            exp_err = (lat >= TIMEOUT);
            exp_ack = 2 + (exp_err ? TIMEOUT - 1 : lat);
            exp_rd  = exp_err ? 32'h0 : (w_we ? m_rdata : rd_fn(w_addr));
            m_rdata = exp_rd;

            ack_at = -1; bad = 0; got_rd = 'x; got_err = 1'bx; got_own = 1'bx;
            for (int k = 1; k <= TIMEOUT + 6 && ack_at < 0; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    n_checks++;
                    if (mem_en !== 1'b1 || mem_addr !== w_addr || mem_we !== w_we || (w_we && mem_wdata !== w_data)) begin
                        n_fail++;
                        $display("FAIL rand_grant_%0d: got en=%b we=%b addr=%h wdata=%h expected 1/%b/%h/%h",
                                 t, mem_en, mem_we, mem_addr, mem_wdata, w_we, w_addr, w_data);
                    end
                end
                if ((win_dma ? core_ack : dma_ack) === 1'b1) bad++;
                if ((win_dma ? dma_ack : core_ack) === 1'b1) begin
                    ack_at = k; got_rd = rdata; got_err = err; got_own = owner;
                end
            end
            n_checks++; if (ack_at != exp_ack) begin n_fail++; $display("FAIL rand_ack_cycle_%0d: got %0d expected %0d", t, ack_at, exp_ack); end
            n_checks++; if (got_err !== exp_err) begin n_fail++; $display("FAIL rand_err_%0d: got %b expected %b", t, got_err, exp_err); end
            n_checks++; if (got_rd !== exp_rd) begin n_fail++; $display("FAIL rand_rdata_%0d: got %h expected %h", t, got_rd, exp_rd); end
            n_checks++; if (got_own !== win_dma) begin n_fail++; $display("FAIL rand_owner_%0d: got %b expected %b", t, got_own, win_dma); end
            n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rand_wrong_ack_%0d: got %0d pulses expected 0", t, bad); end
            if (win_dma) dp = 0; else cp = 0;
            @(negedge clk);
        end
        core_req = 1'b0;
        dma_req  = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_time_limit: got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_core_read();
        test_dma_write();
        test_timeout();
        test_boundary();
        test_starvation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the multicycle processor's single unified memory port. It shares the port between the core's fetch/load/store path and a DMA/loader engine. The core has priority, bounded by a starvation limit that guarantees the DMA a slot. Each access runs as a registered request/ready transaction with a watchdog timeout. The block sits between the core's Adr/WriteData/ReadData path, the DMA engine and the memory model/controller.

## Interface
- AW, 32, address width
- DW, 32, data width
- STARVE, 4, max consecutive core grants while DMA is waiting (≥1)
- TIMEOUT, 16, max BUSY cycles without mem_rdy before abort (≥1)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- core_req  in  1  core access request, held until core_ack
- core_we  in  1  core write (1) / read (0)
- core_addr  in  AW  core byte address
- core_wdata  in  DW  core store data
- core_ack  out  1  one-cycle completion pulse to core
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  same meaning for DMA
- dma_ack  out  1  one-cycle completion pulse to DMA
- rdata  out  DW  registered read data, valid in the ack cycle
- err  out  1  one-cycle pulse with ack when the access timed out
- owner  out  1  requester of the current or last access (0 = core, 1 = DMA)
- mem_en  out  1  memory access strobe, level, held through BUSY
- mem_we  out  1  memory write enable, valid while mem_en=1
- mem_addr  out  AW  memory address, registered
- mem_wdata  out  DW  memory write data, registered
- mem_rdata  in  DW  memory read data, sampled when mem_rdy=1
- mem_rdy  in  1  memory completion, meaningful only while mem_en=1

## Operation
- States: IDLE, BUSY, DONE. Reset enters IDLE.
- IDLE: winner is chosen from the inputs at the rising edge.
  - Only one request: that requester wins.
  - Both requesting: core wins unless streak == STARVE, then DMA wins.
  - Winner's we/addr/wdata are registered onto mem_*. mem_en←1, owner←winner, wcnt←0, next state BUSY.
  - No request: stay in IDLE, mem_en=0.
- Streak counter (width clog2(STARVE+1)):
  - Increments on a core grant while dma_req=1, saturating at STARVE.
  - Clears on any DMA grant.
  - Clears on a core grant with dma_req=0.
- BUSY: mem_* outputs held stable. wcnt increments each cycle.
  - mem_rdy=1: rdata←mem_rdata when mem_we=0; rdata is unchanged on writes. Then mem_en←0, the owner's ack←1, err←0, next state DONE.
  - mem_rdy=0 and wcnt == TIMEOUT-1: abort. mem_en←0, owner's ack←1, err←1, rdata←0, next state DONE.
  - mem_rdy=1 and timeout in the same cycle: mem_rdy wins, err=0.
- DONE: ack and err are high for this one cycle only. Next state is IDLE unconditionally; no arbitration happens in DONE.
- Requester rules:
  - A requester keeps req, we, addr and wdata stable from assertion until it sees ack.
  - It deasserts req, or presents a new request, in the cycle after ack.
  - Changes before ack are ignored, because mem_* were registered at grant.
- A DMA request never preempts an in-flight core access, and a core request never preempts an in-flight DMA access.
- core_ack and dma_ack are never high together.

## Timing
- Reset values: state=IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, core_ack=0, dma_ack=0, rdata=0, err=0, owner=0, streak=0, wcnt=0.
- Reset asserted mid-BUSY: the access is abandoned, mem_en drops asynchronously, and no ack is issued.
- Access with mem_rdy in the first BUSY cycle:
  - Cycle 0: req sampled in IDLE.
  - Cycle 1: mem_en=1, mem_rdy=1.
  - Cycle 2: ack and rdata.
  - Cycle 3: IDLE.
- Latency from request to ack is 2 + (memory wait cycles). Minimum access period is 3 cycles.
- A timed-out access acks at cycle TIMEOUT+1 after the grant edge.
- rdata holds its value until the next completed read or a timeout.

## Test plan
- Single core read: core_addr=0x100, memory returns 0xDEADBEEF with mem_rdy in the first BUSY cycle → mem_en high for exactly 1 cycle with mem_addr=0x100, core_ack 2 cycles after request, rdata=0xDEADBEEF, err=0.
- DMA write with 3 wait cycles: dma_addr=0x40, dma_wdata=0x12345678 → mem_we=1 held for 4 cycles, dma_ack on cycle 5, rdata unchanged.
- Starvation: both requesting continuously, STARVE=4 → grant sequence core,core,core,core,DMA,core…; owner toggles to 1 on the 5th grant.
- Timeout: TIMEOUT=16, mem_rdy never asserted → mem_en high 16 cycles, then core_ack=1 with err=1 and rdata=0, then IDLE.
- Boundary: mem_rdy rises exactly on the 16th BUSY cycle → normal completion with err=0.
- Reset mid-op: reset=0 during the 2nd BUSY cycle of a DMA access → all outputs at reset values immediately, no dma_ack; after release, a new core request completes normally.
